// File: rtl/ksa_frame_acc.sv
// Frame accumulator fed by the 16-bit Kogge-Stone datapath: sums up to COUNT
// unsigned samples per frame and presents sum, count and overflow flag.
module ksa_frame_acc #(
  parameter int COUNT = 16,
  parameter int ACC_W = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [15:0]      in_data_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [ACC_W-1:0] out_data_o,
  output logic [7:0]       out_count_o,
  output logic             out_ovf_o
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_e;

  localparam logic [7:0] COUNT_LAST = 8'(COUNT);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] res_data_q, res_data_d;
  logic [7:0]       res_count_q, res_count_d;
  logic             res_ovf_q, res_ovf_d;
  logic             frame_close;

  logic [ACC_W-1:0] add_b, gen, prop, add_sum;
  logic             add_carry;

  // Parallel-prefix (Kogge-Stone) carry tree keeps the add path at log2(ACC_W) levels.
  always_comb begin
    add_b = ACC_W'(in_data_i);
    gen   = acc_q & add_b;
    prop  = acc_q ^ add_b;
    for (int d = 1; d < ACC_W; d = d * 2) begin
      gen  = gen | (prop & (gen << d));
      prop = prop & ((prop << d) | ~({ACC_W{1'b1}} << d));
    end
    add_sum   = (acc_q ^ add_b) ^ {gen[ACC_W-2:0], 1'b0};
    add_carry = gen[ACC_W-1];
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    res_data_d  = res_data_q;
    res_count_d = res_count_q;
    res_ovf_d   = res_ovf_q;
    frame_close = 1'b0;
    case (state_q)
      ACCUM: begin
        if (in_valid_i) begin
          acc_d = add_sum;
          cnt_d = cnt_q + 8'd1;
          ovf_d = ovf_q | add_carry;
        end
        // cnt_d is nonzero exactly when the frame holds a sample, including this cycle's.
        frame_close = (in_valid_i && (cnt_d == COUNT_LAST)) ||
                      (flush_i && (cnt_d != 8'd0));
        if (frame_close) begin
          res_data_d  = acc_d;
          res_count_d = cnt_d;
          res_ovf_d   = ovf_d;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (out_ready_i) begin
          acc_d   = '0;
          cnt_d   = 8'd0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= 8'd0;
      ovf_q       <= 1'b0;
      res_data_q  <= '0;
      res_count_q <= 8'd0;
      res_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      res_data_q  <= res_data_d;
      res_count_q <= res_count_d;
      res_ovf_q   <= res_ovf_d;
    end
  end

  assign in_ready_o  = (state_q == ACCUM);
  assign out_valid_o = (state_q == HOLD);
  assign out_data_o  = res_data_q;
  assign out_count_o = res_count_q;
  assign out_ovf_o   = res_ovf_q;

endmodule

// File: doc/ksa_frame_acc.md
# ksa_frame_acc

Streaming accumulator that sits directly downstream of the team's 16-bit Kogge-Stone adder datapath. It consumes unsigned 16-bit samples over a valid/ready handshake and sums a frame of COUNT samples (or fewer on flush) into an ACC_W-bit total. It presents each frame result with its sample count and an overflow flag on a valid/ready output port. The accumulator is single-cycle per sample: one add per accepted sample, with the result registered.

## Interface
- COUNT, 16: samples per frame; legal range 2..255.
- ACC_W, 24: accumulator/result width; legal range 16..32.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  16  unsigned sample.
- flush  in  1  close the current frame early; sampled only when in_ready=1.
- out_valid  out  1  frame result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  ACC_W  frame sum, modulo 2^ACC_W.
- out_count  out  8  number of samples in the frame (1..COUNT).
- out_ovf  out  1  sum exceeded 2^ACC_W-1 at any point in the frame.

## Operation
- Two states: ACCUM and HOLD.
- **ACCUM**:
  - in_ready=1, out_valid=0.
  - Accept: in_valid & in_ready. Then acc <= acc + in_data (ACC_W-bit, wrap), cnt <= cnt+1, ovf <= ovf | carry-out of the add.
  - Frame close: accept with cnt+1==COUNT, or flush=1 with (cnt>0 or accept this cycle). On close:
    - out_data <= final sum (including any sample accepted this cycle);
    - out_count <= final count;
    - out_ovf <= final ovf;
    - state <= HOLD.
  - flush with cnt==0 and no accept is ignored.
  - flush together with an accept: the sample is included and the frame closes.
- **HOLD**:
  - in_ready=0, out_valid=1. Outputs are stable until the handshake.
  - On out_valid & out_ready: acc, cnt, ovf <= 0 and state <= ACCUM.
  - No sample is accepted in the handshake cycle.
  - flush is ignored in HOLD.
- Carry detection: an (ACC_W+1)-bit internal sum; bit ACC_W is the carry.
- Reset:
  - state=ACCUM; acc, cnt, ovf = 0.
  - out_valid=0, out_data=0, out_count=0, out_ovf=0; in_ready=1 in the first cycle after reset.
  - Reset mid-frame or in HOLD discards the partial or pending result without emitting it.

## Timing
- in_ready and out_valid are decoded from state only; no combinational path from out_ready or in_valid to in_ready.
- Sample throughput: 1 per cycle in ACCUM.
- Latency: the result is valid (out_valid=1) the cycle after the closing accept or flush.
- Minimum frame turnaround: the last sample in cycle N, out_valid in N+1. With out_ready=1 in N+1, in_ready=1 in N+2.
- Backpressure: out_valid holds indefinitely while out_ready=0. out_data, out_count and out_ovf must not change.
- in_data, flush and in_valid are don't-care when in_ready=0.
- The add path is a single-cycle 16-bit to ACC_W-bit addition and must meet clk timing at the target frequency.

## Test plan
- COUNT=4, ACC_W=24: samples 1,2,3,4 back-to-back with out_ready=1 -> one cycle after sample 4: out_data=10, out_count=4, out_ovf=0; in_ready=1 two cycles after sample 4.
- COUNT=16, ACC_W=20: 16 samples of 0xFFFF -> out_data=0xFFFF0, out_count=16, out_ovf=0.
- COUNT=4, ACC_W=16: samples 0xFFFF, 0x0001, 0x0002, 0x0003 -> out_data=0x0005, out_ovf=1. Next frame 1,1,1,1 -> out_data=4, out_ovf=0 (flag cleared per frame).
- Flush: samples 5,7, then flush=1 with in_valid=1, in_data=9 -> out_data=21, out_count=3. Separately, flush with cnt=0 and in_valid=0 -> no out_valid, state stays ACCUM.
- Backpressure: frame completes with out_ready=0 for 10 cycles -> out_valid=1 and outputs constant, in_ready=0 throughout. in_valid=1 during this window is not counted in the next frame.
- Reset: assert rst after 2 of 4 samples, then drive 4 samples of 1 -> out_data=4, out_count=4. Assert rst during HOLD -> out_valid=0 the next cycle and the result is never emitted.
